// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file
// write port. The arbiter connects through the slave modport; the requester and
// register-file side connects through the master modport.
interface regfile_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    // Requester 0: ALU / immediate writeback
    logic                  Req0_Valid_i;
    logic [4:0]            Req0_Addr_i;
    logic [DATA_WIDTH-1:0] Req0_Data_i;
    logic                  Req0_Ready_o;

    // Requester 1: load / multi-cycle unit
    logic                  Req1_Valid_i;
    logic [4:0]            Req1_Addr_i;
    logic [DATA_WIDTH-1:0] Req1_Data_i;
    logic                  Req1_Ready_o;

    // Register file write port
    logic                  Reg_Write_o;
    logic [4:0]            Write_Register_o;
    logic [DATA_WIDTH-1:0] Write_Data_o;
    logic [31:0]           Write_Select_o;
    logic [3:0]            Wait_Count_o;

    modport slave (
        input  Req0_Valid_i, Req0_Addr_i, Req0_Data_i,
        output Req0_Ready_o,
        input  Req1_Valid_i, Req1_Addr_i, Req1_Data_i,
        output Req1_Ready_o,
        output Reg_Write_o, Write_Register_o, Write_Data_o, Write_Select_o, Wait_Count_o
    );

    modport master (
        output Req0_Valid_i, Req0_Addr_i, Req0_Data_i,
        input  Req0_Ready_o,
        output Req1_Valid_i, Req1_Addr_i, Req1_Data_i,
        input  Req1_Ready_o,
        input  Reg_Write_o, Write_Register_o, Write_Data_o, Write_Select_o, Wait_Count_o
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. Requester 0 has fixed priority; requester 1
// is force-granted after MAX_WAIT consecutive refused cycles. The granted write
// is registered and presented to the register file one cycle later, together
// with a one-hot register select.
//
// Optional build macro: REGFILE_X0_FILTER_EN
//   When defined, accepted writes to register 0 are swallowed at the port
//   (Reg_Write_o and Write_Select_o stay low) while address/data still update.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4   // legal range 1..15
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic                  grant0;
    logic                  grant1;

    logic [3:0]            wait_q, wait_d;
    logic                  we_q, we_d;
    logic [4:0]            reg_q, reg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [31:0]           sel_q, sel_d;

    // Fixed priority to requester 0 unless requester 1 has waited MAX_WAIT cycles
    always_comb begin
        grant1 = bus.Req1_Valid_i & (~bus.Req0_Valid_i | (wait_q == MaxWait));
        grant0 = bus.Req0_Valid_i & ~grant1;
    end

    // Ready is masked during reset so no transfer is reported while state clears
    assign bus.Req0_Ready_o = grant0 & ~reset;
    assign bus.Req1_Ready_o = grant1 & ~reset;

    // Starvation counter: counts refused cycles of a pending requester 1 request
    always_comb begin
        wait_d = wait_q;
        if (!bus.Req1_Valid_i || grant1) begin
            wait_d = 4'd0;
        end else if (wait_q < MaxWait) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // Next write presented to the register file; address/data hold when idle
    always_comb begin
        we_d   = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        sel_d  = 32'd0;
        if (grant1 || grant0) begin
            we_d   = 1'b1;
            reg_d  = grant1 ? bus.Req1_Addr_i : bus.Req0_Addr_i;
            data_d = grant1 ? bus.Req1_Data_i : bus.Req0_Data_i;
            sel_d  = 32'd1 << reg_d;
`ifdef REGFILE_X0_FILTER_EN
            // x0 is hardwired to zero; accept the write but never strobe the port
            if (reg_d == 5'd0) begin
                we_d  = 1'b0;
                sel_d = 32'd0;
            end
`endif
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= 4'd0;
            we_q   <= 1'b0;
            reg_q  <= 5'd0;
            data_q <= '0;
            sel_q  <= 32'd0;
        end else begin
            wait_q <= wait_d;
            we_q   <= we_d;
            reg_q  <= reg_d;
            data_q <= data_d;
            sel_q  <= sel_d;
        end
    end

    assign bus.Reg_Write_o      = we_q;
    assign bus.Write_Register_o = reg_q;
    assign bus.Write_Data_o     = data_q;
    assign bus.Write_Select_o   = sel_q;
    assign bus.Wait_Count_o     = wait_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic checked against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_WAIT = 4;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_write_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    regfile_write_arbiter #(
        .DATA_WIDTH(DW),
        .MAX_WAIT  (MAX_WAIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.Req0_Valid_i = v0;
        bus.Req0_Addr_i  = a0;
        bus.Req0_Data_i  = d0;
        bus.Req1_Valid_i = v1;
        bus.Req1_Addr_i  = a1;
        bus.Req1_Data_i  = d1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 5'd3, 32'h1111, 1'b1, 5'd7, 32'h2222);
        #2;
        n_checks++;
        if (bus.Req0_Ready_o !== 1'b0 || bus.Req1_Ready_o !== 1'b0)
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0",
                     bus.Req0_Ready_o, bus.Req1_Ready_o);
        else n_pass++;
        tick();
        #2;
        n_checks++;
        if (bus.Reg_Write_o !== 1'b0 || bus.Write_Select_o !== 32'd0 ||
            bus.Wait_Count_o !== 4'd0 || bus.Write_Register_o !== 5'd0 ||
            bus.Write_Data_o !== 32'd0)
            $display("FAIL reset_outputs: got we=%b sel=%h wait=%0d reg=%0d data=%h want all 0",
                     bus.Reg_Write_o, bus.Write_Select_o, bus.Wait_Count_o,
                     bus.Write_Register_o, bus.Write_Data_o);
        else n_pass++;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #2;
        n_checks++;
        if (bus.Req0_Ready_o !== 1'b1)
            $display("FAIL single_ready: got %b want 1", bus.Req0_Ready_o);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.Reg_Write_o !== 1'b1 || bus.Write_Register_o !== 5'd5 ||
            bus.Write_Data_o !== 32'hDEADBEEF || bus.Write_Select_o !== 32'h20)
            $display("FAIL single_port: got we=%b reg=%0d data=%h sel=%h want 1 5 deadbeef 20",
                     bus.Reg_Write_o, bus.Write_Register_o, bus.Write_Data_o,
                     bus.Write_Select_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.Reg_Write_o !== 1'b0 || bus.Write_Select_o !== 32'd0 ||
            bus.Write_Register_o !== 5'd5 || bus.Write_Data_o !== 32'hDEADBEEF)
            $display("FAIL single_idle: got we=%b sel=%h reg=%0d data=%h want 0 0 5 deadbeef",
                     bus.Reg_Write_o, bus.Write_Select_o, bus.Write_Register_o,
                     bus.Write_Data_o);
        else n_pass++;
    endtask

    task automatic test_priority();
        drive(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'hBBBB0007);
        #2;
        n_checks++;
        if (bus.Req0_Ready_o !== 1'b1 || bus.Req1_Ready_o !== 1'b0)
            $display("FAIL prio_ready: got r0=%b r1=%b want 1 0",
                     bus.Req0_Ready_o, bus.Req1_Ready_o);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.Reg_Write_o !== 1'b1 || bus.Write_Register_o !== 5'd3 ||
            bus.Wait_Count_o !== 4'd1)
            $display("FAIL prio_first: got we=%b reg=%0d wait=%0d want 1 3 1",
                     bus.Reg_Write_o, bus.Write_Register_o, bus.Wait_Count_o);
        else n_pass++;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hBBBB0007);
        #2;
        n_checks++;
        if (bus.Req1_Ready_o !== 1'b1 || bus.Req0_Ready_o !== 1'b0)
            $display("FAIL prio_second_ready: got r0=%b r1=%b want 0 1",
                     bus.Req0_Ready_o, bus.Req1_Ready_o);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.Reg_Write_o !== 1'b1 || bus.Write_Register_o !== 5'd7 ||
            bus.Write_Data_o !== 32'hBBBB0007 || bus.Write_Select_o !== 32'h80 ||
            bus.Wait_Count_o !== 4'd0)
            $display("FAIL prio_second: got we=%b reg=%0d data=%h sel=%h wait=%0d",
                     bus.Reg_Write_o, bus.Write_Register_o, bus.Write_Data_o,
                     bus.Write_Select_o, bus.Wait_Count_o);
        else n_pass++;
        tick();
    endtask

    task automatic test_starvation();
        logic [4:0] a;
        for (int k = 0; k <= int'(MAX_WAIT); k++) begin
            a = 5'(k + 1);
            drive(1'b1, a, 32'(k), 1'b1, 5'd20, 32'hCAFE0014);
            #2;
            n_checks++;
            if (bus.Wait_Count_o !== 4'(k) || bus.Req0_Ready_o !== (k < int'(MAX_WAIT)) ||
                bus.Req1_Ready_o !== (k == int'(MAX_WAIT)))
                $display("FAIL starve_cycle%0d: got wait=%0d r0=%b r1=%b want %0d %b %b",
                         k, bus.Wait_Count_o, bus.Req0_Ready_o, bus.Req1_Ready_o,
                         k, k < int'(MAX_WAIT), k == int'(MAX_WAIT));
            else n_pass++;
            tick();
        end
        // Forced grant landed on the port; requester 0 wins again next cycle
        n_checks++;
        if (bus.Reg_Write_o !== 1'b1 || bus.Write_Register_o !== 5'd20 ||
            bus.Write_Data_o !== 32'hCAFE0014 || bus.Wait_Count_o !== 4'd0)
            $display("FAIL starve_forced: got we=%b reg=%0d data=%h wait=%0d want 1 20 cafe0014 0",
                     bus.Reg_Write_o, bus.Write_Register_o, bus.Write_Data_o,
                     bus.Wait_Count_o);
        else n_pass++;
        drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd21, 32'h21);
        #2;
        n_checks++;
        if (bus.Req0_Ready_o !== 1'b1 || bus.Req1_Ready_o !== 1'b0)
            $display("FAIL starve_after: got r0=%b r1=%b want 1 0",
                     bus.Req0_Ready_o, bus.Req1_Ready_o);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
    endtask

    task automatic test_x0_write();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        #2;
        n_checks++;
        if (bus.Req1_Ready_o !== 1'b1)
            $display("FAIL x0_ready: got %b want 1", bus.Req1_Ready_o);
        else n_pass++;
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++;
`ifdef REGFILE_X0_FILTER_EN
        if (bus.Reg_Write_o !== 1'b0 || bus.Write_Select_o !== 32'd0 ||
            bus.Write_Register_o !== 5'd0 || bus.Write_Data_o !== 32'h1234)
            $display("FAIL x0_port: got we=%b sel=%h reg=%0d data=%h want 0 0 0 1234",
                     bus.Reg_Write_o, bus.Write_Select_o, bus.Write_Register_o,
                     bus.Write_Data_o);
        else n_pass++;
`else
        if (bus.Reg_Write_o !== 1'b1 || bus.Write_Select_o !== 32'h1 ||
            bus.Write_Register_o !== 5'd0 || bus.Write_Data_o !== 32'h1234)
            $display("FAIL x0_port: got we=%b sel=%h reg=%0d data=%h want 1 1 0 1234",
                     bus.Reg_Write_o, bus.Write_Select_o, bus.Write_Register_o,
                     bus.Write_Data_o);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        // Build up a non-zero wait count first
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC);
        tick();
        n_checks++;
        if (bus.Wait_Count_o !== 4'd1)
            $display("FAIL rstmid_pre_wait: got %0d want 1", bus.Wait_Count_o);
        else n_pass++;
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'hC);
        reset = 1'b1;
        #2;
        n_checks++;
        if (bus.Req0_Ready_o !== 1'b0 || bus.Req1_Ready_o !== 1'b0)
            $display("FAIL rstmid_ready: got r0=%b r1=%b want 0 0",
                     bus.Req0_Ready_o, bus.Req1_Ready_o);
        else n_pass++;
        tick();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_checks++;
        if (bus.Reg_Write_o !== 1'b0 || bus.Wait_Count_o !== 4'd0 ||
            bus.Write_Select_o !== 32'd0 || bus.Write_Register_o !== 5'd0)
            $display("FAIL rstmid_port: got we=%b wait=%0d sel=%h reg=%0d want 0 0 0 0",
                     bus.Reg_Write_o, bus.Wait_Count_o, bus.Write_Select_o,
                     bus.Write_Register_o);
        else n_pass++;
        tick();
    endtask

    // Random traffic against a model built from the arbitration rules
    task automatic test_random();
        logic        p0_v, p1_v, h0, h1, rst, g0, g1, e_we;
        logic [4:0]  p0_a, p1_a, e_reg, ga;
        logic [31:0] p0_d, p1_d, e_data, e_sel;
        int          m_wait;

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        reset = 1'b0;
        m_wait = 0;
        e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0; e_sel = 32'd0;
        h0 = 1'b0; h1 = 1'b0;
        p0_v = 1'b0; p1_v = 1'b0; p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            // A refused request must be held unchanged
            if (!h0) begin
                p0_v = ($urandom_range(3) != 0);
                p0_a = 5'($urandom_range(31));
                p0_d = $urandom;
            end
            if (!h1) begin
                p1_v = ($urandom_range(2) != 0);
                p1_a = 5'($urandom_range(31));
                p1_d = $urandom;
            end
            rst = ($urandom_range(59) == 0);
            reset = rst;
            drive(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d);

            g1 = p1_v && (!p0_v || m_wait == int'(MAX_WAIT));
            g0 = p0_v && !g1;
            #2;
            n_checks++;
            if (bus.Req0_Ready_o !== (g0 && !rst) || bus.Req1_Ready_o !== (g1 && !rst))
                $display("FAIL rand_ready c%0d: got r0=%b r1=%b want %b %b", cyc,
                         bus.Req0_Ready_o, bus.Req1_Ready_o, g0 && !rst, g1 && !rst);
            else n_pass++;
            n_checks++;
            if (bus.Wait_Count_o !== 4'(m_wait))
                $display("FAIL rand_wait c%0d: got %0d want %0d", cyc, bus.Wait_Count_o,
                         m_wait);
            else n_pass++;

            if (rst) begin
                m_wait = 0;
                e_we = 1'b0; e_reg = 5'd0; e_data = 32'd0; e_sel = 32'd0;
                h0 = 1'b0; h1 = 1'b0;
            end else begin
                if (!p1_v || g1) m_wait = 0;
                else if (m_wait < int'(MAX_WAIT)) m_wait = m_wait + 1;
                e_sel = 32'd0;
                if (g0 || g1) begin
                    ga = g1 ? p1_a : p0_a;
                    e_reg = ga;
                    e_data = g1 ? p1_d : p0_d;
                    e_we = 1'b1;
                    e_sel[ga] = 1'b1;
`ifdef REGFILE_X0_FILTER_EN
                    if (ga == 5'd0) begin
                        e_we = 1'b0;
                        e_sel = 32'd0;
                    end
`endif
                end else begin
                    e_we = 1'b0;
                end
                h0 = p0_v && !g0;
                h1 = p1_v && !g1;
            end

            tick();
            n_checks++;
            if (bus.Reg_Write_o !== e_we || bus.Write_Register_o !== e_reg ||
                bus.Write_Data_o !== e_data || bus.Write_Select_o !== e_sel)
                $display("FAIL rand_port c%0d: got we=%b reg=%0d data=%h sel=%h want %b %0d %h %h",
                         cyc, bus.Reg_Write_o, bus.Write_Register_o, bus.Write_Data_o,
                         bus.Write_Select_o, e_we, e_reg, e_data, e_sel);
            else n_pass++;
        end
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        test_reset();
        test_single_write();
        test_priority();
        test_starvation();
        test_x0_write();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two writeback requesters: requester 0 (ALU/immediate writeback) and requester 1 (load/multi-cycle unit). The block sits directly in front of the register file write port. It registers the granted write, including a one-hot register select, and drives the port one cycle later. Requester 0 has fixed priority, and a starvation counter bounds how long requester 1 can wait.

## Interface
- DATA_WIDTH, 32, width of write data
- MAX_WAIT, 4, consecutive refused cycles for requester 1 before it is force-granted; legal range 1..15

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- Req0_Valid_i  in  1  requester 0 has a write pending
- Req0_Addr_i  in  5  requester 0 destination register
- Req0_Data_i  in  DATA_WIDTH  requester 0 write data
- Req0_Ready_o  out  1  requester 0 write accepted this cycle
- Req1_Valid_i  in  1  requester 1 has a write pending
- Req1_Addr_i  in  5  requester 1 destination register
- Req1_Data_i  in  DATA_WIDTH  requester 1 write data
- Req1_Ready_o  out  1  requester 1 write accepted this cycle
- Reg_Write_o  out  1  write enable to register file
- Write_Register_o  out  5  destination register to register file
- Write_Data_o  out  DATA_WIDTH  write data to register file
- Write_Select_o  out  32  one-hot of Write_Register_o; all-zero when Reg_Write_o=0
- Wait_Count_o  out  4  current requester 1 starvation count

## Operation
- Transfer on requester n occurs when Req*n*_Valid_i and Req*n*_Ready_o are both 1.
- Requester inputs must remain stable while valid and not ready.
- Grant logic is combinational from the inputs and wait_cnt:
  - grant1 = Req1_Valid_i & (!Req0_Valid_i | wait_cnt == MAX_WAIT)
  - grant0 = Req0_Valid_i & !grant1
  - Req*n*_Ready_o = grant*n* & !reset
- At most one grant per cycle.
- The register file accepts one write every cycle, so the output stage never back-pressures.
- wait_cnt is a 4-bit counter and the only arbitration state:
  - clears when reset=1, when grant1=1, or when Req1_Valid_i=0
  - otherwise, when Req1_Valid_i=1 and grant1=0, it increments, saturating at MAX_WAIT
- Wait_Count_o = wait_cnt.
- Output stage, registered on each edge:
  - Reg_Write_o <= grant0 | grant1
  - Write_Register_o and Write_Data_o load from the granted requester.
  - Write_Select_o <= 1 << granted address.
  - With no grant: Reg_Write_o <= 0 and Write_Select_o <= 0. Write_Register_o and Write_Data_o hold their previous values.
- Same address from both requesters: the write granted later wins in the register file, because writes land in grant order.
- Reset values: Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, Write_Select_o=0, Wait_Count_o=0. Ready outputs are 0 during reset.
- Reset mid-operation drops any ungranted request and any registered write not yet presented; no write reaches the register file in the cycle after reset is asserted.

## Timing
- Request-to-port latency is 1 cycle: a grant in cycle N appears on Reg_Write_o and related outputs in cycle N+1.
- Ready has zero-cycle latency from valid; there is no combinational path from any output-stage signal to ready.
- Sustained throughput is one write per cycle.
- Worst-case requester 1 wait under continuous requester 0 traffic is MAX_WAIT refused cycles. It is granted on the (MAX_WAIT+1)th cycle of being valid.
- After a forced grant, wait_cnt=0. Requester 0 is granted the following cycle if valid.

## Configuration
- REGFILE_X0_FILTER_EN
  - Defined: a granted write to register 0 is accepted (ready=1, wait_cnt rules unchanged). Reg_Write_o is registered as 0 and Write_Select_o as all-zero for that write; Write_Register_o and Write_Data_o still update.
  - Undefined: register-0 writes pass through like any other address (Reg_Write_o=1, Write_Select_o=32'h1).

## Test plan
- Reset: assert reset with both valid -> both ready=0; next cycle Reg_Write_o=0, Write_Select_o=0, Wait_Count_o=0.
- Single write: Req0 valid, addr 5, data 32'hDEADBEEF for one cycle -> Req0_Ready_o=1 same cycle. Next cycle Reg_Write_o=1, Write_Register_o=5, Write_Data_o=32'hDEADBEEF, Write_Select_o=32'h20. Cycle after, Reg_Write_o=0.
- Priority: both valid, addr 3 and addr 7 -> Req0 granted, Req1_Ready_o=0, Wait_Count_o=1 next cycle. Req0 drops -> Req1 granted, addr 7 written.
- Starvation (MAX_WAIT=4): Req0 valid every cycle, Req1 valid from cycle 0 -> Wait_Count_o counts 1,2,3,4. Cycle 4: Req1_Ready_o=1, Req0_Ready_o=0. Cycle 5: Req1 write on port, Req0 granted again.
- x0 write: Req1 writes addr 0, data 32'h1234 -> with REGFILE_X0_FILTER_EN: Req1_Ready_o=1, next cycle Reg_Write_o=0, Write_Select_o=0. Without: Reg_Write_o=1, Write_Select_o=32'h1.
- Reset mid-operation: grant Req0 addr 9 in cycle N, assert reset in cycle N -> cycle N+1 Reg_Write_o=0 and wait_cnt=0.
